// File: rtl/shift_sequencer_if.sv
// Shift request/response bundle between the control FSM (master) and the
// shift sequencer (slave).
//
// Handshake: the master may raise start for one cycle only while busy is low.
// The request (op, B, shamt) is captured on that edge. The master may change
// op/B/shamt freely afterwards. start while busy is high is ignored; nothing
// is queued. done pulses for one cycle when res holds the new result. res
// holds that result until the next done.
//
// Signals:
//   start  request strobe (master -> slave)
//   op     00 SLL, 01 SRL, 10 SRA, 11 ROTR (master -> slave)
//   B      operand (master -> slave)
//   shamt  shift amount (master -> slave)
//   busy   sequencer not idle (slave -> master)
//   done   one-cycle result-valid pulse (slave -> master)
//   res    result register (slave -> master)
interface shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] B;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;

  modport master (output start, op, B, shamt, input busy, done, res);
  modport slave  (input start, op, B, shamt, output busy, done, res);
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter controller. A request is shifted at most STEP bit
// positions per clock. This keeps the shifter narrow and off the critical
// path. The result is presented with a one-cycle done pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus        shift_sequencer_if slave (start/op/B/shamt in, busy/done/res out)
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int STEP  = 8
) (
  input  logic            clk,
  input  logic            rst,
  shift_sequencer_if.slave bus,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SHW-1:0] STEP_N = SHW'(STEP);
  localparam logic [SHW:0]   WIDTH_N = (SHW+1)'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   rem;
  logic [1:0]       op_q;
  logic             sign;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_q;

  // One chunk of the shift: n = min(rem, STEP).
  logic [SHW-1:0]   n;
  logic [SHW:0]     n_inv;
  logic [SHW-1:0]   rem_next;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    n        = (rem < STEP_N) ? rem : STEP_N;
    n_inv    = WIDTH_N - {1'b0, n};
    rem_next = rem - n;
    shifted  = acc;
    case (op_q)
      2'b00: shifted = acc << n;
      2'b01: shifted = acc >> n;
      // Fill vacated top bits with the sign captured at start.
      2'b10: shifted = (acc >> n) | (sign ? ~({WIDTH{1'b1}} >> n) : {WIDTH{1'b0}});
      // Low bits wrap into the top. When n is 0, acc << WIDTH yields 0.
      2'b11: shifted = (acc >> n) | (acc << n_inv);
      default: shifted = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      op_q   <= '0;
      sign   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            acc    <= bus.B;
            rem    <= bus.shamt;
            op_q   <= bus.op;
            sign   <= bus.B[WIDTH-1];
            busy_q <= 1'b1;
            if (bus.shamt == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
              res_q  <= bus.B;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= shifted;
          rem <= rem_next;
          if (rem_next == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
            res_q  <= shifted;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.res   = res_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         n_checks;
  int         n_fail;
  int         done_cnt;

  shift_sequencer_if #(.WIDTH(32), .SHW(5)) bus ();

  shift_sequencer #(.WIDTH(32), .SHW(5), .STEP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One immediate-assertion comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: issue one request in the current cycle k, then verify busy/done
  // through cycle k+lat (the done cycle) and the return to idle at k+lat+1.
  task automatic run_op(input string tag, input logic [31:0] b, input logic [1:0] o,
                        input logic [4:0] sh, input logic [31:0] exp_res, input int lat);
    bus.start = 1'b1;
    bus.B     = b;
    bus.op    = o;
    bus.shamt = sh;
    tick();
    bus.start = 1'b0;
    bus.B     = $urandom;
    bus.op    = 2'($urandom_range(0, 3));
    bus.shamt = 5'($urandom_range(0, 31));
    for (int c = 1; c < lat; c++) begin
      chk({tag, " busy_run"}, {31'b0, bus.busy}, 32'd1);
      chk({tag, " done_run"}, {31'b0, bus.done}, 32'd0);
      tick();
    end
    chk({tag, " done_pulse"}, {31'b0, bus.done}, 32'd1);
    chk({tag, " busy_done"}, {31'b0, bus.busy}, 32'd1);
    chk({tag, " res"}, bus.res, exp_res);
    tick();
    chk({tag, " done_after"}, {31'b0, bus.done}, 32'd0);
    chk({tag, " busy_after"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, " res_hold"}, bus.res, exp_res);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.B     = '0;
    bus.shamt = '0;
    tick();
    tick();
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset done", {31'b0, bus.done}, 32'd0);
    chk("reset res", bus.res, 32'h0);
    chk("reset state", {30'b0, state_dbg}, 32'd0);
    rst = 1'b0;
    tick();

    // Directed vectors; latency = 1 + ceil(shamt/8).
    run_op("sra_neg3",  32'h80000000, 2'b10, 5'd3,  32'hF0000000, 2);
    run_op("srl_3",     32'h80000000, 2'b01, 5'd3,  32'h10000000, 2);
    run_op("sll_31",    32'h00000001, 2'b00, 5'd31, 32'h80000000, 5);
    run_op("zero_amt",  32'h12345678, 2'b11, 5'd0,  32'h12345678, 1);
    run_op("rotr_31",   32'h0000000F, 2'b11, 5'd31, 32'h0000001E, 5);
    run_op("sra_pos16", 32'h7FFF0000, 2'b10, 5'd16, 32'h00007FFF, 3);
    run_op("sra_neg12", 32'h87654321, 2'b10, 5'd12, 32'hFFF87654, 3);
    run_op("srl_8",     32'hA5A5A5A5, 2'b01, 5'd8,  32'h00A5A5A5, 2);

    // Start while busy must be ignored.
    bus.start = 1'b1;
    bus.B     = 32'h0000000F;
    bus.op    = 2'b11;
    bus.shamt = 5'd4;
    tick();
    chk("ign busy_k1", {31'b0, bus.busy}, 32'd1);
    chk("ign state_k1", {30'b0, state_dbg}, 32'd1);
    bus.B     = 32'h55555555;
    bus.shamt = 5'd0;
    tick();
    bus.start = 1'b0;
    chk("ign done_k2", {31'b0, bus.done}, 32'd1);
    chk("ign res_k2", bus.res, 32'hF0000000);
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.done) done_cnt++;
    end
    chk("ign extra_done", done_cnt, 32'd0);
    chk("ign res_hold", bus.res, 32'hF0000000);
    chk("ign busy_end", {31'b0, bus.busy}, 32'd0);

    // Reset mid-operation aborts with no done and res cleared.
    bus.start = 1'b1;
    bus.B     = 32'h00000001;
    bus.op    = 2'b00;
    bus.shamt = 5'd20;
    tick();
    bus.start = 1'b0;
    chk("abort done_k1", {31'b0, bus.done}, 32'd0);
    tick();
    chk("abort busy_k2", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy_k3", {31'b0, bus.busy}, 32'd0);
    chk("abort res_k3", bus.res, 32'h0);
    chk("abort state_k3", {30'b0, state_dbg}, 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done) done_cnt++;
      tick();
    end
    chk("abort no_done", done_cnt, 32'd0);
    chk("abort res_end", bus.res, 32'h0);

    // Back-to-back after reset recovery.
    run_op("post_abort", 32'hF0000001, 2'b11, 5'd1, 32'hF8000000, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
